// File: rtl/msu_pkg.sv
// Shared constants and fill-FSM state type for the MSU-1 data fetch block.
package msu_pkg;

   localparam int MSU_SECTOR_AW    = 9;
   localparam int MSU_SECTOR_BYTES = 1 << MSU_SECTOR_AW;
   localparam int MSU_BANKS        = 2;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      XFER,
      DRAIN
   } fill_state_t;

endpackage

// File: rtl/msu_dpram.sv
// Two-bank sector buffer: SD-side write port, registered read port for the consumer.
module msu_dpram
   import msu_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int AW     = $clog2(MSU_BANKS * MSU_SECTOR_BYTES)
) (
   input  logic              CLK,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [MSU_BANKS * MSU_SECTOR_BYTES];

   always_ff @(posedge CLK) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/msu_data_fetch.sv
// MSU-1 data channel responder: serves seek/req pulses and streams the data file
// through a two-sector ping-pong buffer filled from the HPS sector interface.
module msu_data_fetch
   import msu_pkg::*;
#(
   parameter int SECTOR_AW = MSU_SECTOR_AW
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 seek,
   input  logic [31:0]          addr,
   input  logic                 req,
   output logic [7:0]           data_out,
   output logic                 busy,
   output logic [31:0]          sd_lba,
   output logic                 sd_rd,
   input  logic                 sd_ack,
   input  logic [SECTOR_AW-1:0] sd_buff_addr,
   input  logic [7:0]           sd_buff_dout,
   input  logic                 sd_buff_wr
);

   localparam logic [SECTOR_AW-1:0] OFF_ONE = SECTOR_AW'(1);

   fill_state_t          state, state_nx;
   logic [MSU_BANKS-1:0] valid;
   logic [31:0]          lba [MSU_BANKS];
   logic                 armed;
   logic                 fill_bank;
   logic                 start_fill;
   logic                 start_bank;
   logic                 fill_done;
   logic                 rd_bank;
   logic [SECTOR_AW-1:0] rd_off;
   logic                 vld_p1;
   logic [7:0]           data_p1;
   logic                 do_req;
   logic                 wrap;
   logic                 ram_we;
   logic [31:0]          seek_lba;

   assign seek_lba = addr >> SECTOR_AW;
   assign do_req   = req & ~seek & ~busy;
   assign wrap     = do_req & (rd_off == '1);
   // Writes are taken only for a live fill; DRAIN and a concurrent seek drop them
   assign ram_we   = sd_buff_wr & ~seek &
                     ((state == XFER) | ((state == REQ) & sd_ack));

   always_comb begin
      state_nx   = state;
      start_fill = 1'b0;
      start_bank = rd_bank;
      fill_done  = 1'b0;
      case (state)
         IDLE: begin
            // The current bank first, so a fresh seek always fills bank 0 before bank 1
            if (armed && !seek) begin
               if (!valid[rd_bank]) begin
                  start_fill = 1'b1;
                  start_bank = rd_bank;
                  state_nx   = REQ;
               end else if (!valid[~rd_bank]) begin
                  start_fill = 1'b1;
                  start_bank = ~rd_bank;
                  state_nx   = REQ;
               end
            end
         end
         REQ: begin
            if (sd_ack) state_nx = seek ? DRAIN : XFER;
         end
         XFER: begin
            if (seek) begin
               state_nx = sd_ack ? DRAIN : IDLE;
            end else if (!sd_ack) begin
               fill_done = 1'b1;
               state_nx  = IDLE;
            end
         end
         DRAIN: begin
            if (!sd_ack) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         armed     <= 1'b0;
         fill_bank <= 1'b0;
         valid     <= '0;
         lba[0]    <= '0;
         lba[1]    <= '0;
         rd_bank   <= 1'b0;
         rd_off    <= '0;
         busy      <= 1'b0;
         vld_p1    <= 1'b0;
         sd_rd     <= 1'b0;
         sd_lba    <= '0;
      end else begin
         state <= state_nx;
         sd_rd <= (state_nx == REQ);

         if (start_fill) begin
            fill_bank <= start_bank;
            sd_lba    <= lba[start_bank];
         end else if (seek && state == REQ && !sd_ack) begin
            fill_bank <= 1'b0;
            sd_lba    <= seek_lba;
         end

         if (seek) begin
            armed   <= 1'b1;
            valid   <= '0;
            lba[0]  <= seek_lba;
            lba[1]  <= seek_lba + 32'd1;
            rd_bank <= 1'b0;
            rd_off  <= addr[SECTOR_AW-1:0];
            busy    <= 1'b1;
            vld_p1  <= 1'b0;
         end else begin
            if (fill_done) valid[fill_bank] <= 1'b1;
            if (do_req) rd_off <= rd_off + OFF_ONE;
            if (wrap) begin
               // Vacated bank is reloaded with the sector after the one now being read
               valid[rd_bank] <= 1'b0;
               lba[rd_bank]   <= lba[rd_bank] + 32'd2;
               rd_bank        <= ~rd_bank;
               busy           <= ~valid[~rd_bank];
               vld_p1         <= 1'b0;
            end else if (busy) begin
               vld_p1 <= valid[rd_bank];
               if (vld_p1) busy <= 1'b0;
            end
         end
      end
   end

   // stage p1: RAM read of the current pointer
   msu_dpram u_ram (
      .CLK   (CLK),
      .we    (ram_we),
      .waddr ({fill_bank, sd_buff_addr}),
      .wdata (sd_buff_dout),
      .raddr ({rd_bank, rd_off}),
      .rdata (data_p1)
   );

   // stage p2: registered output byte
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) data_out <= '0;
      else        data_out <= data_p1;
   end

endmodule

// File: tb/tb_msu_data_fetch.sv
// Self-checking bench for msu_data_fetch: an HPS sector server plus a byte-address reference model.
`timescale 1ns/1ps
module tb_msu_data_fetch;
   import msu_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        seek = 1'b0;
   logic [31:0] addr = '0;
   logic        req = 1'b0;
   logic [7:0]  data_out;
   logic        busy;
   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_ack = 1'b0;
   logic [8:0]  sd_buff_addr = '0;
   logic [7:0]  sd_buff_dout = '0;
   logic        sd_buff_wr = 1'b0;

   int          n_chk = 0;
   int          n_err = 0;
   int          hps_delay = 3;
   int          stall_cnt = 0;
   bit          seq_phase = 1'b0;
   logic [31:0] served[$];
   logic [31:0] p;

   always #5 CLK = ~CLK;

   msu_data_fetch dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .seek         (seek),
      .addr         (addr),
      .req          (req),
      .data_out     (data_out),
      .busy         (busy),
      .sd_lba       (sd_lba),
      .sd_rd        (sd_rd),
      .sd_ack       (sd_ack),
      .sd_buff_addr (sd_buff_addr),
      .sd_buff_dout (sd_buff_dout),
      .sd_buff_wr   (sd_buff_wr)
   );

   // Contents of the .msu file at byte address a; sector 0 is simply i & 0xFF
   function automatic logic [7:0] fbyte(input logic [31:0] a);
      logic [7:0] s;
      s = a[16:9];
      return a[7:0] + s * 8'h3B;
   endfunction

   function automatic logic [31:0] get_served(input int idx);
      if (idx < served.size()) return served[idx];
      return 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // HPS side: serve each sd_rd after hps_delay cycles, one sector of file bytes
   initial begin : hps
      logic [31:0] cap;
      forever begin
         @(negedge CLK);
         if (sd_rd === 1'b1) begin
            repeat (hps_delay) @(negedge CLK);
            cap = sd_lba;
            served.push_back(cap);
            sd_ack = 1'b1;
            for (int i = 0; i < 512; i++) begin
               @(negedge CLK);
               sd_buff_addr = i[8:0];
               sd_buff_dout = fbyte({cap[22:0], i[8:0]});
               sd_buff_wr   = 1'b1;
               @(negedge CLK);
               sd_buff_wr   = 1'b0;
               if ($urandom_range(0, 3) == 0) @(negedge CLK);
            end
            @(negedge CLK);
            sd_ack = 1'b0;
            @(negedge CLK);
         end
      end
   end

   always @(negedge CLK) if (seq_phase && busy) stall_cnt <= stall_cnt + 1;

   task automatic wait_ready(input string tag, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge CLK);
         n++;
      end
      if (busy) chk({tag, "_timeout"}, busy, 0);
   endtask

   task automatic wait_rd(input string tag, input int budget);
      int n = 0;
      while (!sd_rd && n < budget) begin
         @(negedge CLK);
         n++;
      end
      if (!sd_rd) chk({tag, "_timeout"}, sd_rd, 1);
   endtask

   task automatic wait_ack(input string tag, input logic lvl, input int budget);
      int n = 0;
      while (sd_ack !== lvl && n < budget) begin
         @(negedge CLK);
         n++;
      end
      if (sd_ack !== lvl) chk({tag, "_timeout"}, sd_ack, lvl);
   endtask

   task automatic wait_quiet(input int budget);
      int n = 0;
      int q = 0;
      while (q < 4 && n < budget) begin
         @(negedge CLK);
         n++;
         if (!sd_rd && !sd_ack) q++;
         else q = 0;
      end
      if (q < 4) chk("quiet_timeout", q, 4);
   endtask

   task automatic do_seek(input logic [31:0] a);
      seek = 1'b1;
      addr = a;
      @(negedge CLK);
      seek = 1'b0;
      p = a;
      chk("seek_busy", busy, 1);
   endtask

   task automatic step(input string tag);
      req = 1'b1;
      @(negedge CLK);
      req = 1'b0;
      p = p + 1;
      repeat (4) @(negedge CLK);
      wait_ready(tag, 5000);
      chk(tag, data_out, fbyte(p));
   endtask

   initial begin
      repeat (3) @(negedge CLK);
      chk("rst_data_out", data_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sd_rd", sd_rd, 0);
      chk("rst_sd_lba", sd_lba, 0);
      RST_N = 1'b1;
      repeat (4) @(negedge CLK);
      chk("idle_no_rd", sd_rd, 0);

      // First seek from reset: bank 0 gets sector 0, then sector 1 is requested
      do_seek(32'h0000_0000);
      wait_rd("t1_rd", 100);
      chk("t1_lba", sd_lba, 0);
      wait_ready("t1_ready", 4000);
      chk("t1_data", data_out, fbyte(p));
      wait_quiet(4000);
      chk("t1_next_lba", get_served(1), 1);

      // Seek into the middle of sector 1
      do_seek(32'h0000_0205);
      wait_rd("t3_rd", 100);
      chk("t3_lba", sd_lba, 1);
      wait_ready("t3_ready", 4000);
      chk("t3_data", data_out, fbyte(p));
      for (int i = 0; i < 3; i++) step("t3_step");
      chk("t3_ptr", p, 32'h0000_0208);

      // Sequential 1536-byte stream with no stalls after the first fill
      wait_quiet(4000);
      served.delete();
      do_seek(32'h0000_0000);
      wait_ready("t4_ready", 4000);
      chk("t4_first", data_out, fbyte(p));
      seq_phase = 1'b1;
      for (int i = 1; i < 1536; i++) step("t4_byte");
      seq_phase = 1'b0;
      chk("t4_stalls", stall_cnt, 0);
      chk("t4_lba0", get_served(0), 0);
      chk("t4_lba1", get_served(1), 1);
      chk("t4_lba2", get_served(2), 2);
      chk("t4_lba3", get_served(3), 3);

      // Sector boundary while the next bank's fill is held off by 200 cycles
      wait_quiet(4000);
      hps_delay = 200;
      do_seek(32'h0000_03F0);
      wait_ready("t5_ready0", 5000);
      chk("t5_start", data_out, fbyte(p));
      for (int i = 0; i < 15; i++) step("t5_pre");
      req = 1'b1;
      @(negedge CLK);
      req = 1'b0;
      p = p + 1;
      chk("t5_wrap_busy", busy, 1);
      repeat (5) @(negedge CLK);
      req = 1'b1;
      @(negedge CLK);
      req = 1'b0;
      wait_ready("t5_ready1", 5000);
      repeat (2) @(negedge CLK);
      chk("t5_first", data_out, fbyte(p));
      hps_delay = 3;
      step("t5_after");

      // Seek during an in-flight transfer: the transfer drains, then sector 8 is fetched
      wait_quiet(5000);
      do_seek(32'h0000_0000);
      wait_ack("t6_ack", 1'b1, 200);
      repeat (40) @(negedge CLK);
      do_seek(32'h0000_1000);
      wait_ack("t6_ackfall", 1'b0, 4000);
      chk("t6_busy_drain", busy, 1);
      wait_rd("t6_rd", 100);
      chk("t6_lba", sd_lba, 8);
      wait_ready("t6_ready", 4000);
      chk("t6_data", data_out, fbyte(p));
      step("t6_s1");
      step("t6_s2");

      // seek and req together: the seek wins and the pointer is not advanced
      wait_quiet(4000);
      seek = 1'b1;
      req  = 1'b1;
      addr = 32'h0000_1003;
      @(negedge CLK);
      seek = 1'b0;
      req  = 1'b0;
      p = 32'h0000_1003;
      chk("t7_busy", busy, 1);
      wait_ready("t7_ready", 4000);
      chk("t7_data", data_out, fbyte(p));
      step("t7_s1");

      // Reset in the middle of a transfer; late writes must be ignored
      wait_quiet(4000);
      do_seek(32'h0000_2000);
      wait_ack("t8_ack", 1'b1, 200);
      repeat (20) @(negedge CLK);
      RST_N = 1'b0;
      #1;
      chk("t8_rst_data", data_out, 0);
      chk("t8_rst_busy", busy, 0);
      chk("t8_rst_rd", sd_rd, 0);
      chk("t8_rst_lba", sd_lba, 0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (5) @(negedge CLK);
      chk("t8_idle_rd", sd_rd, 0);
      chk("t8_idle_busy", busy, 0);
      wait_quiet(4000);
      chk("t8_post_rd", sd_rd, 0);
      do_seek(32'h0000_2200);
      wait_rd("t8_rd", 100);
      chk("t8_lba", sd_lba, 17);
      wait_ready("t8_ready", 4000);
      chk("t8_data", data_out, fbyte(p));
      step("t8_s1");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
